cc_psr_stack: RTL and testbench

Parametrised processor status register with a nested trap save/restore stack. Holds the live PSR word {S, ET, CC[FLAG_WIDTH-1:0]}. CC bits are updated from the ALU under a per-flag mask. On trap entry it pushes the live PSR onto an internal LIFO; on trap return it pops it back. Sits between the ALU flag outputs, the control unit's condition-code/trap sequencer and the branch-condition evaluator.

---
 rtl/cc_psr_stack.sv | 103 ++++++++++
 tb/tb_cc_psr_stack.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cc_psr_stack.sv
// Processor status register {S, ET, CC} with masked flag updates and a
// saturating LIFO of saved PSR words for nested trap entry and return.
module cc_psr_stack #(
  parameter  int FLAG_WIDTH  = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int PSR_WIDTH   = FLAG_WIDTH + 2,
  localparam int CNT_WIDTH   = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  CC_PSRSTACK_CLOCK_50,
  input  logic                  CC_PSRSTACK_RESET_InLow,
  input  logic [FLAG_WIDTH-1:0] CC_PSRSTACK_SetMask_In,
  input  logic [FLAG_WIDTH-1:0] CC_PSRSTACK_Flags_In,
  input  logic                  CC_PSRSTACK_WrPsr_In,
  input  logic [PSR_WIDTH-1:0]  CC_PSRSTACK_WrData_In,
  input  logic                  CC_PSRSTACK_Push_In,
  input  logic                  CC_PSRSTACK_Pop_In,
  input  logic                  CC_PSRSTACK_ErrClr_In,
  output logic [PSR_WIDTH-1:0]  CC_PSRSTACK_Psr_Out,
  output logic [FLAG_WIDTH-1:0] CC_PSRSTACK_CC_Out,
  output logic [CNT_WIDTH-1:0]  CC_PSRSTACK_Depth_Out,
  output logic                  CC_PSRSTACK_Full_Out,
  output logic                  CC_PSRSTACK_Empty_Out,
  output logic [1:0]            CC_PSRSTACK_Err_Out
);

  localparam int IDX_WIDTH = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PSR_WIDTH-1:0]  psr_q;
  logic [PSR_WIDTH-1:0]  psr_nxt;
  logic [CNT_WIDTH-1:0]  depth_q;
  logic [CNT_WIDTH-1:0]  depth_nxt;
  logic [1:0]            err_q;
  logic [1:0]            err_set;
  logic [1:0]            err_nxt;
  logic                  push_we;
  logic [FLAG_WIDTH-1:0] merged_cc;
  logic [PSR_WIDTH-1:0]  merged_psr;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  top_idx;
  logic                  is_full;
  logic                  is_empty;
  logic [PSR_WIDTH-1:0]  stack_mem [STACK_DEPTH];

  assign merged_cc  = (psr_q[FLAG_WIDTH-1:0] & ~CC_PSRSTACK_SetMask_In) |
                      (CC_PSRSTACK_Flags_In & CC_PSRSTACK_SetMask_In);
  assign merged_psr = {psr_q[PSR_WIDTH-1:FLAG_WIDTH], merged_cc};
  assign is_full    = (depth_q == CNT_WIDTH'(STACK_DEPTH));
  assign is_empty   = (depth_q == '0);
  assign wr_idx     = IDX_WIDTH'(depth_q);
  assign top_idx    = IDX_WIDTH'(depth_q - 1'b1);

  // Command priority: push&pop, pop, push, software write, mask update
  always_comb begin
    psr_nxt   = merged_psr;
    depth_nxt = depth_q;
    err_set   = 2'b00;
    push_we   = 1'b0;
    if (CC_PSRSTACK_Push_In && CC_PSRSTACK_Pop_In) begin
      psr_nxt = merged_psr;
    end else if (CC_PSRSTACK_Pop_In) begin
      if (!is_empty) begin
        psr_nxt   = stack_mem[top_idx];
        depth_nxt = depth_q - 1'b1;
      end else begin
        err_set[0] = 1'b1;
      end
    end else if (CC_PSRSTACK_Push_In) begin
      psr_nxt = {1'b1, 1'b0, merged_cc};
      if (!is_full) begin
        push_we   = 1'b1;
        depth_nxt = depth_q + 1'b1;
      end else begin
        err_set[1] = 1'b1;
      end
    end else if (CC_PSRSTACK_WrPsr_In) begin
      psr_nxt = CC_PSRSTACK_WrData_In;
    end
    // A fresh error outranks a same-cycle clear
    err_nxt = (CC_PSRSTACK_ErrClr_In ? 2'b00 : err_q) | err_set;
  end

  always_ff @(posedge CC_PSRSTACK_CLOCK_50) begin
    if (!CC_PSRSTACK_RESET_InLow) begin
      psr_q   <= {1'b1, 1'b0, {FLAG_WIDTH{1'b0}}};
      depth_q <= '0;
      err_q   <= 2'b00;
      for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
    end else begin
      psr_q   <= psr_nxt;
      depth_q <= depth_nxt;
      err_q   <= err_nxt;
      if (push_we) stack_mem[wr_idx] <= merged_psr;
    end
  end

  assign CC_PSRSTACK_Psr_Out   = psr_q;
  assign CC_PSRSTACK_CC_Out    = psr_q[FLAG_WIDTH-1:0];
  assign CC_PSRSTACK_Depth_Out = depth_q;
  assign CC_PSRSTACK_Full_Out  = is_full;
  assign CC_PSRSTACK_Empty_Out = is_empty;
  assign CC_PSRSTACK_Err_Out   = err_q;

endmodule

// File: tb/tb_cc_psr_stack.sv
// Self-checking bench for cc_psr_stack: directed vector table followed by
// randomized traffic checked against a queue-based reference model.
module tb_cc_psr_stack;

  localparam int FW = 4;
  localparam int SD = 4;
  localparam int PW = FW + 2;
  localparam int CW = $clog2(SD + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] set_mask;
  logic [FW-1:0] flags;
  logic          wr_psr;
  logic [PW-1:0] wr_data;
  logic          push;
  logic          pop;
  logic          err_clr;
  logic [PW-1:0] psr;
  logic [FW-1:0] cc;
  logic [CW-1:0] depth;
  logic          full;
  logic          empty;
  logic [1:0]    err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cc_psr_stack #(.FLAG_WIDTH(FW), .STACK_DEPTH(SD)) dut (
    .CC_PSRSTACK_CLOCK_50    (clk),
    .CC_PSRSTACK_RESET_InLow (rst_n),
    .CC_PSRSTACK_SetMask_In  (set_mask),
    .CC_PSRSTACK_Flags_In    (flags),
    .CC_PSRSTACK_WrPsr_In    (wr_psr),
    .CC_PSRSTACK_WrData_In   (wr_data),
    .CC_PSRSTACK_Push_In     (push),
    .CC_PSRSTACK_Pop_In      (pop),
    .CC_PSRSTACK_ErrClr_In   (err_clr),
    .CC_PSRSTACK_Psr_Out     (psr),
    .CC_PSRSTACK_CC_Out      (cc),
    .CC_PSRSTACK_Depth_Out   (depth),
    .CC_PSRSTACK_Full_Out    (full),
    .CC_PSRSTACK_Empty_Out   (empty),
    .CC_PSRSTACK_Err_Out     (err)
  );

  typedef struct {
    logic          rst_n;
    logic [FW-1:0] mask;
    logic [FW-1:0] flags;
    logic          wr;
    logic [PW-1:0] wdata;
    logic          push;
    logic          pop;
    logic          clr;
    logic [PW-1:0] exp_psr;
    int            exp_depth;
    logic [1:0]    exp_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [PW-1:0] m_psr;
  logic [PW-1:0] m_stack[$];
  logic [1:0]    m_err;

  function automatic vec_t mk(logic r, logic [FW-1:0] m, logic [FW-1:0] f,
                              logic w, logic [PW-1:0] wd, logic pu, logic po,
                              logic c, logic [PW-1:0] ep, int ed, logic [1:0] ee);
    vec_t v;
    v.rst_n = r; v.mask = m; v.flags = f; v.wr = w; v.wdata = wd;
    v.push = pu; v.pop = po; v.clr = c;
    v.exp_psr = ep; v.exp_depth = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic check_all(string tag, logic [PW-1:0] ep, int ed, logic [1:0] ee);
    check_output({tag, " psr"},   32'(psr), 32'(ep));
    check_output({tag, " cc"},    32'(cc), 32'(ep[FW-1:0]));
    check_output({tag, " depth"}, 32'(depth), 32'(ed));
    check_output({tag, " err"},   32'(err), 32'(ee));
    check_output({tag, " full"},  32'(full), 32'(ed == SD));
    check_output({tag, " empty"}, 32'(empty), 32'(ed == 0));
  endtask

  task automatic apply_stimulus(vec_t v);
    rst_n = v.rst_n; set_mask = v.mask; flags = v.flags; wr_psr = v.wr;
    wr_data = v.wdata; push = v.push; pop = v.pop; err_clr = v.clr;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: one edge of the PSR/stack rules
  task automatic model_step(vec_t v);
    logic [FW-1:0] mcc;
    logic [1:0]    new_err;
    mcc = (m_psr[FW-1:0] & ~v.mask) | (v.flags & v.mask);
    new_err = 2'b00;
    if (!v.rst_n) begin
      m_psr = {2'b10, {FW{1'b0}}};
      m_stack.delete();
      m_err = 2'b00;
      return;
    end
    if (v.push && v.pop) begin
      m_psr = {m_psr[PW-1:FW], mcc};
    end else if (v.pop) begin
      if (m_stack.size() > 0) m_psr = m_stack.pop_back();
      else begin
        m_psr = {m_psr[PW-1:FW], mcc};
        new_err[0] = 1'b1;
      end
    end else if (v.push) begin
      if (m_stack.size() < SD) m_stack.push_back({m_psr[PW-1:FW], mcc});
      else new_err[1] = 1'b1;
      m_psr = {2'b10, mcc};
    end else if (v.wr) begin
      m_psr = v.wdata;
    end else begin
      m_psr = {m_psr[PW-1:FW], mcc};
    end
    m_err = (v.clr ? 2'b00 : m_err) | new_err;
  endtask

  initial begin
    vec_t v;
    //                 rst  mask     flags    wr  wdata       pu  po  clr  exp_psr     dep err
    vecs.push_back(mk(0, 4'hF,    4'hF,    0, 6'b00_0000, 1, 0, 0, 6'b10_0000, 0, 2'b00));
    vecs.push_back(mk(0, 4'hF,    4'hF,    0, 6'b00_0000, 1, 0, 0, 6'b10_0000, 0, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 0, 0, 6'b10_0000, 0, 2'b00));
    vecs.push_back(mk(1, 4'b0101, 4'b1111, 0, 6'b00_0000, 0, 0, 0, 6'b10_0101, 0, 2'b00));
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 0, 6'b00_0000, 0, 0, 0, 6'b10_0101, 0, 2'b00));
    vecs.push_back(mk(1, 4'b0000, 4'b1111, 0, 6'b00_0000, 0, 0, 0, 6'b10_0101, 0, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    1, 6'b01_0011, 0, 0, 0, 6'b01_0011, 0, 2'b00));
    vecs.push_back(mk(1, 4'hF,    4'b1000, 0, 6'b00_0000, 1, 0, 0, 6'b10_1000, 1, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b01_1000, 0, 2'b00));
    // overflow: four saves, a fifth rejected, then unwind and underflow
    vecs.push_back(mk(1, 4'h0,    4'h0,    1, 6'b01_0110, 0, 0, 0, 6'b01_0110, 0, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 1, 0, 0, 6'b10_0110, 1, 2'b00));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 0, 6'b00_0000, 1, 0, 0, 6'b10_0111, 2, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 1, 0, 0, 6'b10_0111, 3, 2'b00));
    vecs.push_back(mk(1, 4'b1000, 4'b1000, 0, 6'b00_0000, 1, 0, 0, 6'b10_1111, 4, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 1, 0, 0, 6'b10_1111, 4, 2'b10));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b10_1111, 3, 2'b10));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b10_0111, 2, 2'b10));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b10_0111, 1, 2'b10));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b01_0110, 0, 2'b10));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b01_0110, 0, 2'b11));
    // clear racing a new underflow, then a plain clear
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 1, 6'b01_0110, 0, 2'b01));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 0, 1, 6'b01_0110, 0, 2'b00));
    // simultaneous push&pop, pop beating a software write
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 1, 0, 0, 6'b10_0110, 1, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 1, 0, 0, 6'b10_0110, 2, 2'b00));
    vecs.push_back(mk(1, 4'b0001, 4'b0001, 1, 6'b00_0000, 1, 1, 0, 6'b10_0111, 2, 2'b00));
    vecs.push_back(mk(1, 4'hF,    4'h0,    1, 6'b11_1111, 0, 1, 0, 6'b10_0110, 1, 2'b00));
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b01_0110, 0, 2'b00));
    // reset mid-nesting
    vecs.push_back(mk(1, 4'h0,    4'h0,    0, 6'b00_0000, 1, 0, 0, 6'b10_0110, 1, 2'b00));
    vecs.push_back(mk(0, 4'h0,    4'h0,    0, 6'b00_0000, 0, 1, 0, 6'b10_0000, 0, 2'b00));

    rst_n = 1'b0; set_mask = '0; flags = '0; wr_psr = 1'b0; wr_data = '0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    #1;

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i].exp_psr, vecs[i].exp_depth, vecs[i].exp_err);
    end

    // Hold after reset release: nothing changes without a command
    v = mk(1, 4'h0, 4'h0, 0, 6'b00_0000, 0, 0, 0, 6'b00_0000, 0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(v);
      check_all("hold", 6'b10_0000, 0, 2'b00);
    end

    // Randomized traffic against the reference model
    m_psr = {2'b10, {FW{1'b0}}};
    m_stack.delete();
    m_err = 2'b00;
    for (int i = 0; i < 600; i++) begin
      v.rst_n = ($urandom_range(0, 99) != 0);
      v.mask  = FW'($urandom);
      v.flags = FW'($urandom);
      v.wr    = ($urandom_range(0, 3) == 0);
      v.wdata = PW'($urandom);
      v.push  = ($urandom_range(0, 2) == 0);
      v.pop   = ($urandom_range(0, 2) == 0);
      v.clr   = ($urandom_range(0, 7) == 0);
      model_step(v);
      apply_stimulus(v);
      check_all($sformatf("rnd%0d", i), m_psr, m_stack.size(), m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
